// File: rtl/spi_arb.sv
// rtl/spi_arb.sv - round-robin arbiter for the shared SPI master (optional abort: SPI_ARB_TIMEOUT_EN)
module spi_arb #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  lock,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    input  logic [15:0] cmd2,
    input  logic        SPIrdy,
    input  logic [15:0] spiRXdata,
    output logic        startSPI,
    output logic [15:0] spiTXdata,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic [15:0] rdData,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_RDY,
        S_COMPLETE
    } state_t;

    state_t      state, state_n;
    logic [1:0]  idx, idx_n;
    logic [1:0]  ptr, ptr_n;
    logic [1:0]  bcnt, bcnt_n;
    logic [15:0] tx_n, rd_n;
    logic [2:0]  gnt_n;
    logic [1:0]  first, second, win;
    logic        win_valid;
    logic [15:0] cmd_win, cmd_idx;
    logic        timed_out;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tcnt, tcnt_n;
    logic        terr, terr_n;
    assign timed_out = terr;
`else
    assign timed_out = 1'b0;
`endif

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [15:0] cmd_of(input logic [1:0] i,
                                           input logic [15:0] c0,
                                           input logic [15:0] c1,
                                           input logic [15:0] c2);
        case (i)
            2'd0:    return c0;
            2'd1:    return c1;
            default: return c2;
        endcase
    endfunction

    // Round-robin pick: the requester after the last served one wins first, last served wins last
    always_comb begin
        first     = rr_next(ptr);
        second    = rr_next(first);
        win       = ptr;
        win_valid = 1'b0;
        if (req[first]) begin
            win       = first;
            win_valid = 1'b1;
        end else if (req[second]) begin
            win       = second;
            win_valid = 1'b1;
        end else if (req[ptr]) begin
            win       = ptr;
            win_valid = 1'b1;
        end
        cmd_win = cmd_of(win, cmd0, cmd1, cmd2);
        cmd_idx = cmd_of(idx, cmd0, cmd1, cmd2);
    end

    // Next-state and next-value logic for the arbitration FSM
    always_comb begin
        state_n = state;
        idx_n   = idx;
        ptr_n   = ptr;
        bcnt_n  = bcnt;
        tx_n    = spiTXdata;
        rd_n    = rdData;
        gnt_n   = gnt;
`ifdef SPI_ARB_TIMEOUT_EN
        tcnt_n  = tcnt;
        terr_n  = terr;
`endif
        case (state)
            S_IDLE: begin
                gnt_n = 3'b000;
                if (win_valid) begin
                    idx_n   = win;
                    tx_n    = cmd_win;
                    gnt_n   = 3'b001 << win;
                    state_n = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                bcnt_n  = 2'd0;
                state_n = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // A master that never shows busy is assumed to have finished already
                if (!SPIrdy || bcnt == 2'd3) begin
                    state_n = S_WAIT_RDY;
`ifdef SPI_ARB_TIMEOUT_EN
                    tcnt_n  = 16'd0;
`endif
                end else begin
                    bcnt_n = bcnt + 2'd1;
                end
            end
            S_WAIT_RDY: begin
                if (SPIrdy) begin
                    rd_n    = spiRXdata;
                    state_n = S_COMPLETE;
`ifdef SPI_ARB_TIMEOUT_EN
                    terr_n  = 1'b0;
                end else if (tcnt == TO_LAST) begin
                    rd_n    = 16'hFFFF;
                    terr_n  = 1'b1;
                    state_n = S_COMPLETE;
                end else begin
                    tcnt_n = tcnt + 16'd1;
`endif
                end
            end
            S_COMPLETE: begin
                // A locked owner keeps the bus; an aborted transfer always releases it
                if (lock[idx] && req[idx] && !timed_out) begin
                    tx_n    = cmd_idx;
                    state_n = S_LAUNCH;
                end else begin
                    ptr_n   = idx;
                    gnt_n   = 3'b000;
                    state_n = S_IDLE;
                end
            end
            default: begin
                gnt_n   = 3'b000;
                state_n = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= 2'd0;
            ptr       <= 2'd2;
            bcnt      <= 2'd0;
            spiTXdata <= 16'h0000;
            rdData    <= 16'h0000;
            gnt       <= 3'b000;
`ifdef SPI_ARB_TIMEOUT_EN
            tcnt      <= 16'd0;
            terr      <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            ptr       <= ptr_n;
            bcnt      <= bcnt_n;
            spiTXdata <= tx_n;
            rdData    <= rd_n;
            gnt       <= gnt_n;
`ifdef SPI_ARB_TIMEOUT_EN
            tcnt      <= tcnt_n;
            terr      <= terr_n;
`endif
        end
    end

    assign startSPI = (state == S_LAUNCH);
    assign done     = (state == S_COMPLETE) ? (3'b001 << idx) : 3'b000;
    assign err      = (state == S_COMPLETE) && timed_out;

endmodule

// File: tb/tb_spi_arb.sv
// tb/tb_spi_arb.sv - scoreboard bench for spi_arb
module tb_spi_arb;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [15:0] cmd0, cmd1, cmd2;
    logic        SPIrdy;
    logic [15:0] spiRXdata;
    logic        startSPI;
    logic [15:0] spiTXdata;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [15:0] rdData;
    logic        err;

    spi_arb #(.TIMEOUT(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .cmd0      (cmd0),
        .cmd1      (cmd1),
        .cmd2      (cmd2),
        .SPIrdy    (SPIrdy),
        .spiRXdata (spiRXdata),
        .startSPI  (startSPI),
        .spiTXdata (spiTXdata),
        .gnt       (gnt),
        .done      (done),
        .rdData    (rdData),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  g;
        logic [15:0] tx;
    } launch_t;

    typedef struct {
        logic [2:0]  d;
        logic [15:0] rd;
        logic        e;
    } done_t;

    launch_t     lq[$];
    done_t       dq[$];
    logic [15:0] rx_q[$];

    int checks = 0;
    int errors = 0;
    int idle_cnt = 0;
    int model_lat = 3;
    bit model_hang = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic exp_launch(input logic [2:0] g, input logic [15:0] tx);
        launch_t l;
        l.g  = g;
        l.tx = tx;
        lq.push_back(l);
    endtask

    task automatic exp_done(input logic [2:0] d, input logic [15:0] rd, input logic e);
        done_t x;
        x.d  = d;
        x.rd = rd;
        x.e  = e;
        dq.push_back(x);
    endtask

    // SPI master model: goes busy on launch, returns the next queued word after model_lat cycles
    initial begin
        SPIrdy    = 1'b1;
        spiRXdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (startSPI && !rst) begin
                SPIrdy = 1'b0;
                if (!model_hang) begin
                    repeat (model_lat) @(negedge clk);
                    spiRXdata = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hDEAD;
                    SPIrdy    = 1'b1;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT launches or completes
    initial begin
        launch_t l;
        done_t   x;
        forever begin
            @(negedge clk);
            chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
            if (err && done == 3'b000) chk("err_without_done", {31'd0, err}, 32'd0);
            if (gnt == 3'b000) idle_cnt++;
            if (startSPI) begin
                if (lq.size() == 0) begin
                    chk("unexpected_launch_gnt", {29'd0, gnt}, 32'd0);
                end else begin
                    l = lq.pop_front();
                    chk("launch_gnt", {29'd0, gnt}, {29'd0, l.g});
                    chk("launch_tx", {16'd0, spiTXdata}, {16'd0, l.tx});
                end
            end
            if (done != 3'b000) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", {29'd0, done}, 32'd0);
                end else begin
                    x = dq.pop_front();
                    chk("done_idx", {29'd0, done}, {29'd0, x.d});
                    chk("done_rdData", {16'd0, rdData}, {16'd0, x.rd});
                    chk("done_err", {31'd0, err}, {31'd0, x.e});
                end
            end
        end
    end

    task automatic wait_done(input int budget, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 3'b000 && n < budget);
        checks++;
        if (done == 3'b000) begin
            errors++;
            $display("FAIL %s: no done within %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_done_drop(input int budget, input string nm);
        wait_done(budget, nm);
        req = req & ~done;
    endtask

    task automatic all_three(input string nm);
        exp_launch(3'b001, cmd0);
        exp_launch(3'b010, cmd1);
        exp_launch(3'b100, cmd2);
        rx_q.push_back(16'h1111);
        rx_q.push_back(16'h2222);
        rx_q.push_back(16'h3333);
        exp_done(3'b001, 16'h1111, 1'b0);
        exp_done(3'b010, 16'h2222, 1'b0);
        exp_done(3'b100, 16'h3333, 1'b0);
        req = 3'b111;
        repeat (3) wait_done_drop(100, nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int snap;
        rst  = 1'b1;
        req  = 3'b000;
        lock = 3'b000;
        cmd0 = 16'hC000;
        cmd1 = 16'h2A5C;
        cmd2 = 16'hC002;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {11'd0, startSPI, spiTXdata, gnt, done, rdData, err} == 0 ? 32'd0 : 32'd1, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single request from requester 1
        model_lat = 20;
        exp_launch(3'b010, 16'h2A5C);
        rx_q.push_back(16'h00C3);
        exp_done(3'b010, 16'h00C3, 1'b0);
        req = 3'b010;
        @(negedge clk);
        chk("single_gnt_n1", {29'd0, gnt}, 32'h2);
        chk("single_start_n1", {31'd0, startSPI}, 32'd1);
        @(negedge clk);
        chk("single_start_one_cycle", {31'd0, startSPI}, 32'd0);
        wait_done_drop(100, "single_done");
        @(negedge clk);
        chk("single_gnt_release", {29'd0, gnt}, 32'd0);
        chk("single_rdData_held", {16'd0, rdData}, 32'h00C3);

        // contention 111 from a fresh pointer: order 0,1,2
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmd1 = 16'hC001;
        model_lat = 3;
        all_three("contention_111");

        // contention 101: order 0 then 2 with an idle cycle between
        exp_launch(3'b001, 16'hC000);
        exp_launch(3'b100, 16'hC002);
        rx_q.push_back(16'h5A5A);
        rx_q.push_back(16'hA5A5);
        exp_done(3'b001, 16'h5A5A, 1'b0);
        exp_done(3'b100, 16'hA5A5, 1'b0);
        req = 3'b101;
        wait_done_drop(100, "contention_101_a");
        @(negedge clk);
        chk("contention_101_idle_gap", {29'd0, gnt}, 32'd0);
        @(negedge clk);
        chk("contention_101_second_gnt", {29'd0, gnt}, 32'h4);
        wait_done_drop(100, "contention_101_b");

        // locked three-command sequence by requester 0 with requester 2 pending
        cmd0 = 16'h0500;
        lock = 3'b001;
        exp_launch(3'b001, 16'h0500);
        exp_launch(3'b001, 16'h0400);
        exp_launch(3'b001, 16'h0400);
        exp_launch(3'b100, 16'hC002);
        rx_q.push_back(16'h0101);
        rx_q.push_back(16'h0202);
        rx_q.push_back(16'h0303);
        rx_q.push_back(16'h0404);
        exp_done(3'b001, 16'h0101, 1'b0);
        exp_done(3'b001, 16'h0202, 1'b0);
        exp_done(3'b001, 16'h0303, 1'b0);
        exp_done(3'b100, 16'h0404, 1'b0);
        req = 3'b101;
        @(negedge clk);
        snap = idle_cnt;
        wait_done(100, "locked_1");
        cmd0 = 16'h0400;
        @(negedge clk);
        chk("locked_relaunch_m2", {28'd0, startSPI, gnt}, {28'd0, 1'b1, 3'b001});
        wait_done(100, "locked_2");
        wait_done(100, "locked_3");
        req  = 3'b100;
        lock = 3'b000;
        chk("locked_no_idle_gap", idle_cnt, snap);
        wait_done_drop(100, "locked_then_2");

        // withdrawal of requester 1 and late drop by granted requester 0
        model_lat = 10;
        exp_launch(3'b001, 16'h0400);
        rx_q.push_back(16'h4444);
        exp_done(3'b001, 16'h4444, 1'b0);
        req = 3'b001;
        @(negedge clk);
        req = 3'b011;
        repeat (2) @(negedge clk);
        req = 3'b000;
        wait_done(100, "late_drop_done");
        repeat (15) @(negedge clk);
        chk("withdrawn_never_granted", {29'd0, gnt}, 32'd0);

        // reset during WAIT_RDY
        model_lat = 30;
        cmd0 = 16'hC000;
        exp_launch(3'b001, 16'hC000);
        rx_q.push_back(16'hBEEF);
        req = 3'b001;
        repeat (8) @(negedge clk);
        chk("pre_reset_busy_gnt", {29'd0, gnt}, 32'h1);
        rst = 1'b1;
        req = 3'b000;
        @(negedge clk);
        chk("midreset_outputs", {11'd0, startSPI, spiTXdata, gnt, done, rdData, err} == 0 ? 32'd0 : 32'd1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (35) @(negedge clk);
        model_lat = 3;
        all_three("after_reset_111");

`ifdef SPI_ARB_TIMEOUT_EN
        // master hangs busy: abort after 32 cycles in WAIT_RDY, bus released despite lock
        model_hang = 1'b1;
        exp_launch(3'b001, 16'hC000);
        exp_done(3'b001, 16'hFFFF, 1'b1);
        lock = 3'b001;
        req  = 3'b001;
        @(negedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 3'b000 && n < 60);
        chk("timeout_latency", n, 34);
        @(negedge clk);
        chk("timeout_bus_released", {29'd0, gnt}, 32'd0);
        req  = 3'b000;
        lock = 3'b000;
        repeat (5) @(negedge clk);
`else
        // master hangs busy: without the abort the owner waits indefinitely
        model_hang = 1'b1;
        exp_launch(3'b001, 16'hC000);
        lock = 3'b001;
        req  = 3'b001;
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (err) n++;
        end
        chk("no_timeout_err_cycles", n, 0);
        chk("no_timeout_still_granted", {28'd0, done == 3'b000, gnt}, {28'd0, 1'b1, 3'b001});
        req  = 3'b000;
        lock = 3'b000;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("launch_queue_drained", lq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_arb.md
# spi_arb

Arbitrates the single EEPROM/AFE SPI master between three requesters: the dump sequencer (calibration gain/offset reads), the AFE gain configuration writer and the trigger-level configuration writer. Each requester presents a 16-bit command. The arbiter grants round-robin, launches the SPI transaction, collects read data and returns a completion pulse. A lock input lets one requester issue back-to-back transactions without losing the bus, for example the three-command gain/offset read.

## Interface
- `TIMEOUT`, default 1024: cycles allowed in WAIT_RDY before a transaction is aborted (used only with `SPI_ARB_TIMEOUT_EN`).
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 3: per-requester request. Bit 0 is the dump SM, bit 1 is AFE gain, bit 2 is the trigger config.
- `lock` input 3: per-requester hold-bus. Sampled only in COMPLETE.
- `cmd0`, `cmd1`, `cmd2` input 16 each: command words, stable while the matching `req` is high.
- `SPIrdy` input 1: SPI master idle/finished.
- `spiRXdata` input 16: SPI master read data.
- `startSPI` output 1: one-cycle launch pulse to the SPI master.
- `spiTXdata` output 16: latched command of the granted requester.
- `gnt` output 3: one-hot grant, registered.
- `done` output 3: one-hot, one-cycle completion pulse.
- `rdData` output 16: read data, shared. Valid in the `done` cycle and held until the next completion.
- `err` output 1: one-cycle abort pulse, coincident with `done`.

## Operation
- States:
  - IDLE: `gnt`=0. If any `req` is high, pick the winner by round-robin, latch its index and `cmd` into `spiTXdata`, set `gnt` → LAUNCH.
  - LAUNCH: `startSPI`=1 for exactly one cycle → WAIT_BUSY.
  - WAIT_BUSY: wait for `SPIrdy`=0 → WAIT_RDY. If `SPIrdy` stays 1 for 4 cycles, treat the transfer as already finished → WAIT_RDY.
  - WAIT_RDY: on `SPIrdy`=1, latch `spiRXdata` into `rdData` → COMPLETE.
  - COMPLETE: pulse `done[idx]`.
    - If `lock[idx]` and `req[idx]` are both 1: latch `cmd[idx]` and keep `gnt` → LAUNCH. The pointer is not updated.
    - Otherwise: pointer ← idx, clear `gnt` → IDLE.
- Round-robin: priority order starts at pointer+1 mod 3. After reset the pointer is 2, so `req[0]` has highest priority first.
- Late arrivals: a `req` that rises while another requester is granted waits. A requester that drops `req` before being granted is withdrawn with no side effects. Dropping `req` after grant is ignored; the transaction completes and `done` still pulses.
- Simultaneous requests in IDLE: exactly one is granted per round-robin. The others stay pending and are served in pointer order.
- Idle gap: an unlocked completion always passes through one IDLE cycle before the next LAUNCH.
- Reset values: `startSPI`=0, `spiTXdata`=16'h0000, `gnt`=0, `done`=0, `rdData`=16'h0000, `err`=0. Pointer=2, state=IDLE.
- Reset mid-transaction: all outputs take their reset values on the next edge and no `done` is issued. The SPI master's own reset is responsible for aborting the transfer.

## Timing
- `req` sampled high in IDLE at edge N:
  - `gnt` and `spiTXdata` valid from N+1.
  - `startSPI` high for cycle N+1 only.
- Minimum transaction, with `SPIrdy` falling at N+2 and rising at edge M: `rdData` updates at M+1 and `done` pulses in cycle M+1.
- Unlocked: `gnt` deasserts at M+2.
- Locked: `gnt` is held. The next `startSPI` is in cycle M+2 and its `spiTXdata` is the `cmd` sampled in COMPLETE.
- `gnt` is one-hot or zero at all times. `done` and `err` never assert outside COMPLETE.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter runs in WAIT_RDY.
  - When it reaches `TIMEOUT`, the arbiter goes to COMPLETE with `rdData`=16'hFFFF, `err`=1 and `done[idx]`=1.
  - After a timeout, the lock is ignored and the bus is always released.
- `SPI_ARB_TIMEOUT_EN` undefined:
  - No counter. WAIT_RDY waits indefinitely.
  - `err` is tied to 0 and `TIMEOUT` is unused.

## Test plan
- **Single request:** `req`=3'b010, `cmd1`=16'h2A5C, SPI model returns 16'h00C3 after 20 cycles → `gnt`=010 at N+1, `startSPI` one cycle with `spiTXdata`=16'h2A5C, `done`=010 with `rdData`=16'h00C3.
- **Contention:** `req`=3'b111 held, each requester drops its `req` after its `done` → grant order 0,1,2. Repeat with 3'b101 → order 0,2, with one IDLE cycle between grants.
- **Locked sequence:** requester 0 holds `lock`=1 for three commands 16'h0500, 16'h0400, 16'h0400 with `req[2]` pending throughout → three back-to-back launches to requester 0, no IDLE gap, `gnt` stays 001, then requester 2 is granted.
- **Withdrawal and late drop:**
  - `req[1]` pulses for 2 cycles while requester 0 is busy → never granted.
  - Granted requester drops `req` mid-transfer → `done` still pulses.
- **Reset mid-transfer:** assert `rst` in WAIT_RDY → next edge all outputs 0, no `done`. The first grant after reset goes to requester 0 when all three request.
- **Timeout (macro on, `TIMEOUT`=32):** `SPIrdy` held low after launch → `done` and `err` pulse 32 cycles into WAIT_RDY with `rdData`=16'hFFFF, bus released despite `lock`=1. With the macro off, the same stimulus leaves the FSM in WAIT_RDY and `err` never asserts.
